// File: rtl/vga_video_tx_if.sv
// Pixel stream link between a frame producer and the VGA transmitter.
// The producer side uses the master modport and the transmitter uses the slave modport.
interface vga_video_tx_if;
    logic [23:0] pix_rgb;
    logic        pix_sof;
    logic        pix_valid;
    logic        pix_ready;

    modport master (
        output pix_rgb,
        output pix_sof,
        output pix_valid,
        input  pix_ready
    );

    modport slave (
        input  pix_rgb,
        input  pix_sof,
        input  pix_valid,
        output pix_ready
    );
endinterface

// File: rtl/vga_video_tx.sv
// VGA transmitter: raster counters, registered sync/video outputs and a pull-style pixel interface.
// Underrun and start-of-frame misalignment are reported through sticky status flags.
module vga_video_tx #(
    parameter int unsigned HOR_ACT   = 640,
    parameter int unsigned HOR_FP    = 16,
    parameter int unsigned HOR_SYNC  = 96,
    parameter int unsigned HOR_BP    = 48,
    parameter int unsigned VERT_ACT  = 480,
    parameter int unsigned VERT_FP   = 11,
    parameter int unsigned VERT_SYNC = 2,
    parameter int unsigned VERT_BP   = 31,
    parameter logic        HSYNC_POL = 1'b0,
    parameter logic        VSYNC_POL = 1'b0
) (
    input  logic          pixel_clk,
    input  logic          rst,
    input  logic          en,
    input  logic          clr_status,
    vga_video_tx_if.slave pix,
    output logic [7:0]    r,
    output logic [7:0]    g,
    output logic [7:0]    b,
    output logic          hsync,
    output logic          vsync,
    output logic          de,
    output logic          frame_start,
    output logic          underrun,
    output logic          sync_err
);
    localparam logic [10:0] H_ACT  = 11'(HOR_ACT);
    localparam logic [10:0] H_SS   = 11'(HOR_ACT + HOR_FP);
    localparam logic [10:0] H_SE   = 11'(HOR_ACT + HOR_FP + HOR_SYNC);
    localparam logic [10:0] H_LAST = 11'(HOR_ACT + HOR_FP + HOR_SYNC + HOR_BP - 1);
    localparam logic [10:0] V_ACT  = 11'(VERT_ACT);
    localparam logic [10:0] V_SS   = 11'(VERT_ACT + VERT_FP);
    localparam logic [10:0] V_SE   = 11'(VERT_ACT + VERT_FP + VERT_SYNC);
    localparam logic [10:0] V_LAST = 11'(VERT_ACT + VERT_FP + VERT_SYNC + VERT_BP - 1);

    typedef enum logic {IDLE, RUN} state_e;

    state_e      state_q, state_d;
    logic [10:0] h_cnt_q, h_cnt_d;
    logic [10:0] v_cnt_q, v_cnt_d;
    logic [23:0] rgb_q, rgb_d;
    logic        hsync_q, hsync_d;
    logic        vsync_q, vsync_d;
    logic        de_q, de_d;
    logic        frame_start_q, frame_start_d;
    logic        underrun_q, underrun_d;
    logic        sync_err_q, sync_err_d;

    logic active, accept, at_origin, frame_end;

    always_comb begin
        active    = (state_q == RUN) && (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
        at_origin = (h_cnt_q == '0) && (v_cnt_q == '0);
        frame_end = (h_cnt_q == H_LAST) && (v_cnt_q == V_LAST);
        pix.pix_ready = active && !rst;
        accept    = pix.pix_ready && pix.pix_valid;

        state_d       = state_q;
        h_cnt_d       = h_cnt_q;
        v_cnt_d       = v_cnt_q;
        rgb_d         = '0;
        de_d          = 1'b0;
        hsync_d       = ~HSYNC_POL;
        vsync_d       = ~VSYNC_POL;
        frame_start_d = 1'b0;

        case (state_q)
            IDLE: begin
                h_cnt_d = '0;
                v_cnt_d = '0;
                if (en) state_d = RUN;
            end
            RUN: begin
                if (h_cnt_q == H_LAST) begin
                    h_cnt_d = '0;
                    v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 11'd1;
                end else begin
                    h_cnt_d = h_cnt_q + 11'd1;
                end
                // Leaving RUN is only allowed at the frame boundary so a frame is never truncated.
                if (frame_end && !en) state_d = IDLE;

                de_d          = active;
                rgb_d         = accept ? pix.pix_rgb : '0;
                hsync_d       = (h_cnt_q >= H_SS && h_cnt_q < H_SE) ? HSYNC_POL : ~HSYNC_POL;
                vsync_d       = (v_cnt_q >= V_SS && v_cnt_q < V_SE) ? VSYNC_POL : ~VSYNC_POL;
                frame_start_d = at_origin;
            end
            default: state_d = IDLE;
        endcase

        // New events win over a simultaneous clear.
        underrun_d = (active && !pix.pix_valid) || (underrun_q && !clr_status);
        sync_err_d = (accept && (pix.pix_sof != at_origin)) || (sync_err_q && !clr_status);
    end

    always_ff @(posedge pixel_clk) begin
        if (rst) begin
            state_q       <= IDLE;
            h_cnt_q       <= '0;
            v_cnt_q       <= '0;
            rgb_q         <= '0;
            de_q          <= 1'b0;
            hsync_q       <= ~HSYNC_POL;
            vsync_q       <= ~VSYNC_POL;
            frame_start_q <= 1'b0;
            underrun_q    <= 1'b0;
            sync_err_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            h_cnt_q       <= h_cnt_d;
            v_cnt_q       <= v_cnt_d;
            rgb_q         <= rgb_d;
            de_q          <= de_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            frame_start_q <= frame_start_d;
            underrun_q    <= underrun_d;
            sync_err_q    <= sync_err_d;
        end
    end

    assign {r, g, b}   = rgb_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign de          = de_q;
    assign frame_start = frame_start_q;
    assign underrun    = underrun_q;
    assign sync_err    = sync_err_q;
endmodule

// File: tb/tb_vga_video_tx.sv
// Bench for vga_video_tx on a 14x8 raster: vector table, randomized run against a frame-position
// model, and directed sequences for underrun, misaligned sof, en drop and mid-frame reset.
module tb_vga_video_tx;
    localparam int HA = 8, HF = 2, HS = 3, HB = 1;
    localparam int VA = 4, VF = 1, VS = 2, VB = 1;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int FT = HT * VT;

    logic       clk = 1'b0;
    logic       rst, en, clr;
    logic [7:0] r, g, b;
    logic       hsync, vsync, de, fs, underrun, sync_err;

    vga_video_tx_if pix();

    vga_video_tx #(
        .HOR_ACT(HA), .HOR_FP(HF), .HOR_SYNC(HS), .HOR_BP(HB),
        .VERT_ACT(VA), .VERT_FP(VF), .VERT_SYNC(VS), .VERT_BP(VB),
        .HSYNC_POL(1'b0), .VSYNC_POL(1'b0)
    ) dut (
        .pixel_clk(clk), .rst(rst), .en(en), .clr_status(clr), .pix(pix),
        .r(r), .g(g), .b(b), .hsync(hsync), .vsync(vsync), .de(de),
        .frame_start(fs), .underrun(underrun), .sync_err(sync_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model state: whether a frame is running and the position within it as a flat cycle index.
    bit          m_run = 1'b0;
    int          m_pos = 0;
    bit          m_u = 1'b0, m_s = 1'b0;
    logic [23:0] e_rgb;
    bit          e_de, e_hs, e_vs, e_fs;
    bit          pre_ready, last_acc;
    int          pix_n = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t pos=%0d)", nm, act, exp, $time, m_pos);
        end
    endtask

    task automatic cycle();
        int h, v;
        bit act, acc;
        #1;
        h = m_pos % HT;
        v = m_pos / HT;
        act = m_run && h < HA && v < VA && !rst;
        pre_ready = pix.pix_ready;
        chk("pix_ready", pix.pix_ready, act);
        acc = act && pix.pix_valid;
        e_rgb = '0; e_de = 0; e_hs = 1; e_vs = 1; e_fs = 0;
        if (rst) begin
            m_run = 0; m_pos = 0; m_u = 0; m_s = 0;
        end else begin
            if (m_run) begin
                e_de  = h < HA && v < VA;
                e_rgb = acc ? pix.pix_rgb : 24'h0;
                e_hs  = !(h >= HA + HF && h < HA + HF + HS);
                e_vs  = !(v >= VA + VF && v < VA + VF + VS);
                e_fs  = (m_pos == 0);
            end
            m_u = (act && !pix.pix_valid) || (m_u && !clr);
            m_s = (acc && (pix.pix_sof != (m_pos == 0))) || (m_s && !clr);
            if (m_run) begin
                if (m_pos == FT - 1 && !en) begin
                    m_run = 0; m_pos = 0;
                end else begin
                    m_pos = (m_pos + 1) % FT;
                end
            end else if (en) begin
                m_run = 1; m_pos = 0;
            end
        end
        if (acc) pix_n++;
        last_acc = acc;
        @(posedge clk);
        #1;
        chk("rgb", {r, g, b}, e_rgb);
        chk("de", de, e_de);
        chk("hsync", hsync, e_hs);
        chk("vsync", vsync, e_vs);
        chk("frame_start", fs, e_fs);
        chk("underrun", underrun, m_u);
        chk("sync_err", sync_err, m_s);
    endtask

    task automatic drive_default();
        rst = 0;
        clr = 0;
        pix.pix_valid = 1;
        pix.pix_sof = (m_pos == 0);
        pix.pix_rgb = {8'h5A, 16'(pix_n)};
    endtask

    task automatic run_to(input int p);
        bit ok = 0;
        for (int i = 0; i < 2 * FT; i++) begin
            if (m_run && m_pos == p) begin
                ok = 1;
                break;
            end
            drive_default();
            cycle();
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL run_to: position %0d not reached, got run=%0d pos=%0d", p, m_run, m_pos);
        end
    endtask

    typedef struct {
        bit          rst, en, valid, sof;
        logic [23:0] rgb;
        bit          x_ready, x_de, x_fs, x_hs, x_vs;
        logic [23:0] x_rgb;
    } vec_t;

    vec_t tbl[5];

    initial begin
        int n_de, n_vl, n_hl, n_acc, held;

        tbl[0] = '{1, 0, 0, 0, 24'h000000, 0, 0, 0, 1, 1, 24'h000000};
        tbl[1] = '{0, 0, 1, 0, 24'h123456, 0, 0, 0, 1, 1, 24'h000000};
        tbl[2] = '{0, 1, 1, 1, 24'h123456, 0, 0, 0, 1, 1, 24'h000000};
        tbl[3] = '{0, 1, 1, 1, 24'h111111, 1, 1, 1, 1, 1, 24'h111111};
        tbl[4] = '{0, 1, 1, 0, 24'h222222, 1, 1, 0, 1, 1, 24'h222222};

        rst = 1; en = 0; clr = 0;
        pix.pix_valid = 0; pix.pix_sof = 0; pix.pix_rgb = '0;

        for (int i = 0; i < 5; i++) begin
            rst = tbl[i].rst; en = tbl[i].en; clr = 0;
            pix.pix_valid = tbl[i].valid; pix.pix_sof = tbl[i].sof; pix.pix_rgb = tbl[i].rgb;
            cycle();
            chk("tbl_ready", pre_ready, tbl[i].x_ready);
            chk("tbl_de", de, tbl[i].x_de);
            chk("tbl_fs", fs, tbl[i].x_fs);
            chk("tbl_hsync", hsync, tbl[i].x_hs);
            chk("tbl_vsync", vsync, tbl[i].x_vs);
            chk("tbl_rgb", {r, g, b}, tbl[i].x_rgb);
        end

        // Randomized traffic with occasional gaps, stray sof and status clears.
        en = 1;
        for (int i = 0; i < 3 * FT; i++) begin
            rst = 0;
            clr = ($urandom_range(0, 19) == 0);
            pix.pix_valid = ($urandom_range(0, 9) < 8);
            pix.pix_sof = (m_pos == 0) ^ ($urandom_range(0, 19) == 0);
            pix.pix_rgb = 24'($urandom);
            cycle();
        end
        run_to(10);
        drive_default(); clr = 1; cycle();
        chk("clr_after_random", {underrun, sync_err}, 2'b00);

        // One clean frame: accept and sync-pulse counts.
        run_to(0);
        n_de = 0; n_vl = 0; n_hl = 0; n_acc = 0;
        for (int i = 0; i < FT; i++) begin
            drive_default();
            cycle();
            n_de += de; n_vl += !vsync; n_hl += !hsync; n_acc += last_acc;
        end
        chk("frame_de_cycles", n_de, 32);
        chk("frame_accepts", n_acc, 32);
        chk("vsync_low_cycles", n_vl, 28);
        chk("hsync_low_cycles", n_hl, 24);

        // Three-cycle source gap on line 1.
        run_to(14);
        for (int i = 0; i < 3; i++) begin
            drive_default(); pix.pix_valid = 0; cycle();
            chk("gap_de", de, 1);
            chk("gap_rgb", {r, g, b}, 24'h0);
        end
        chk("underrun_set", underrun, 1);
        held = pix_n;
        drive_default(); cycle();
        chk("resume_pixel", {r, g, b}, {8'h5A, 16'(held)});
        chk("underrun_sticky", underrun, 1);
        run_to(22);
        drive_default(); clr = 1; cycle();
        chk("underrun_cleared", underrun, 0);

        // sof on pixel 5 instead of pixel 0.
        run_to(0);
        drive_default(); pix.pix_sof = 0; cycle();
        chk("sof_missing", sync_err, 1);
        run_to(5);
        drive_default(); pix.pix_sof = 1; cycle();
        run_to(8);
        drive_default(); clr = 1; cycle();
        chk("sync_err_cleared", sync_err, 0);
        run_to(19);
        drive_default(); pix.pix_sof = 1; clr = 1; cycle();
        chk("clr_vs_new_err", sync_err, 1);
        run_to(22);
        drive_default(); clr = 1; cycle();

        // en dropped on line 2: frame completes, then IDLE.
        run_to(28);
        en = 0;
        for (int i = 0; i < 2 * FT && m_run; i++) begin
            drive_default(); cycle();
        end
        drive_default(); cycle();
        chk("idle_ready", pre_ready, 0);
        chk("idle_outputs", {de, hsync, vsync, fs}, 4'b0110);
        drive_default(); cycle();
        en = 1;
        drive_default(); cycle();
        drive_default(); cycle();
        chk("restart_fs", fs, 1);

        // Reset in the middle of active video.
        run_to(33);
        drive_default(); rst = 1; cycle();
        chk("rst_ready", pre_ready, 0);
        chk("rst_outputs", {de, hsync, vsync, fs, underrun, sync_err}, 6'b011000);
        chk("rst_rgb", {r, g, b}, 24'h0);
        drive_default(); cycle();
        drive_default(); cycle();
        chk("rst_restart_fs", fs, 1);
        drive_default(); cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
        $fatal(1);
    end
endmodule

// File: doc/vga_video_tx.md
# vga_video_tx

Cycle-accurate VGA transmitter: generates hsync/vsync and 24-bit RGB video from a streaming pixel source using VESA-style timing. It is the driving end of the VGA link and sits between a frame producer (test pattern, framebuffer reader) and the VGA monitor model on the virtual devboard. It pulls exactly one pixel per active-video cycle and flags underruns and frame-alignment errors.

## Interface
- HOR_ACT, 640, active pixels per line
- HOR_FP, 16, horizontal front porch (pixels)
- HOR_SYNC, 96, hsync width (pixels)
- HOR_BP, 48, horizontal back porch (pixels)
- VERT_ACT, 480, active lines per frame
- VERT_FP, 11, vertical front porch (lines)
- VERT_SYNC, 2, vsync width (lines)
- VERT_BP, 31, vertical back porch (lines)
- HSYNC_POL, 0, hsync active level (0 = active-low)
- VSYNC_POL, 0, vsync active level (0 = active-low)

Ports:
- pixel_clk  in  1  pixel clock; all logic on rising edge
- rst  in  1  reset; one clock, synchronous, active-high
- en  in  1  run request
- clr_status  in  1  clears sticky status flags
- pix_rgb  in  24  pixel {r[7:0],g[7:0],b[7:0]}
- pix_sof  in  1  marks first pixel of a frame
- pix_valid  in  1  pixel available
- pix_ready  out  1  pixel consumed this cycle (pix_valid & pix_ready = accept)
- r, g, b  out  8 each  video outputs
- hsync, vsync  out  1  sync outputs
- de  out  1  active-video indicator
- frame_start  out  1  one-cycle pulse with first output pixel of a frame
- underrun  out  1  sticky: active cycle with no pixel available
- sync_err  out  1  sticky: pix_sof misaligned with frame start

## Operation
- H_TOT = HOR_ACT+HOR_FP+HOR_SYNC+HOR_BP; V_TOT likewise. Counters h_cnt, v_cnt are 11 bits; all parameters sum ≤ 2047.
- Line order: active [0,HOR_ACT), front porch, sync [HOR_ACT+HOR_FP, HOR_ACT+HOR_FP+HOR_SYNC), back porch. Same for lines; vsync asserted for whole lines v_cnt in [VERT_ACT+VERT_FP, +VERT_SYNC).
- h_cnt wraps H_TOT-1→0; v_cnt increments on h wrap, wraps V_TOT-1→0.
- States: IDLE, RUN. Reset → IDLE. IDLE→RUN when en=1 sampled; first RUN cycle has counters (0,0). RUN→IDLE only when en=0 in the last cycle of a frame (h=H_TOT-1, v=V_TOT-1); en deassertion mid-frame completes the frame.
- IDLE: counters held at 0, pix_ready=0, outputs at inactive values.
- pix_ready (combinational) = RUN & h_cnt<HOR_ACT & v_cnt<VERT_ACT & ~rst.
- Active cycle with pix_valid=1: pixel accepted, registered to r/g/b, de=1.
- Active cycle with pix_valid=0: r/g/b=0, de=1, underrun set; no pixel consumed; position advances.
- sync_err set on accept at (0,0) with pix_sof=0, or accept elsewhere with pix_sof=1. Pixel still displayed; no realignment.
- Sticky flags: set has priority over clr_status in the same cycle; clr_status otherwise clears both next edge.

## Timing
- All outputs registered; outputs in cycle n reflect counter position and accepted pixel of cycle n-1 (latency 1 from accept to r/g/b).
- hsync/vsync/de/frame_start aligned with r/g/b on the same edge.
- frame_start=1 in the output cycle corresponding to position (0,0) in RUN.
- Reset values: r=g=b=0, de=0, hsync=~HSYNC_POL, vsync=~VSYNC_POL, frame_start=0, underrun=0, sync_err=0, pix_ready=0, state IDLE, counters 0.
- rst mid-frame: next cycle all outputs at reset values; no pixel accepted during rst.
- Outputs in IDLE equal reset values.

## Test plan
Parameters for all: HOR 8/2/3/1 (H_TOT=14), VERT 4/1/2/1 (V_TOT=8), frame=112 cycles, polarity 0.
- Reset then en=1, source always valid with incrementing pix_rgb, sof on first -> first edge after RUN entry gives frame_start=1, de=1, rgb=pixel 0; 32 pixels accepted per frame; hsync low for output cycles of h_cnt 10..12; vsync low for lines 5..6 (28 cycles).
- Source drops pix_valid for 3 active cycles at line 1 -> those outputs rgb=0, de=1, underrun=1 and stays set; next pixel shown is the unconsumed one.
- sof on pixel 5 of frame instead of pixel 0 -> sync_err=1 after first accept without sof at (0,0); clr_status pulse in blanking -> sync_err=0 next cycle; clr_status coincident with new error -> flag stays 1.
- en dropped at line 2 -> frame completes, IDLE entered after cycle (13,7); outputs hsync=vsync=1, de=0, pix_ready=0; en reasserted -> new frame_start.
- rst asserted at (5,2) mid-active -> next cycle all outputs at reset values, pix_ready=0; after release with en=1 timing restarts at (0,0).
